// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the fetch-stage controller.
package fetch_pkg;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } fetch_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with synchronous flush and occupancy count.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic             do_push, do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && (count != '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: count gates every read that matters.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/fetch_ctrl.sv
// Fetch PC owner: credit-limited requests to imem, in-order response buffer,
// redirect squash with a drop counter for responses still in flight.
module fetch_ctrl import fetch_pkg::*; #(
  parameter int                ADDRESS_WIDTH = 32,
  parameter int                DATA_WIDTH    = 32,
  parameter [ADDRESS_WIDTH-1:0] RESET_PC     = 32'h0000_0000,
  parameter int                DEPTH         = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall_f,
  input  logic                     pc_src_e,
  input  logic [ADDRESS_WIDTH-1:0] pc_target_e,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [ADDRESS_WIDTH-1:0] imem_req_addr,
  input  logic                     imem_resp_valid,
  input  logic [DATA_WIDTH-1:0]    imem_resp_data,
  output logic [ADDRESS_WIDTH-1:0] pc_f,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4_f,
  output logic [DATA_WIDTH-1:0]    instr_f,
  output logic                     instr_valid_f
);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0]    instr;
  } fetch_entry_t;

  fetch_state_t             state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] fetch_pc, pcq_dout;
  logic [CW-1:0]            outstanding, drop_cnt, drop_next, pcq_count, ibuf_count;
  logic [CW:0]              used;
  logic                     run_en, acc, resp, pop, in_run, credit_ok;
  fetch_entry_t             ibuf_din, ibuf_dout;

  assign acc       = imem_req_valid && imem_req_ready;
  assign resp      = imem_resp_valid;
  assign in_run    = (state_q == RUN) && !pc_src_e;
  assign pop       = instr_valid_f && !stall_f && !pc_src_e;
  assign drop_next = outstanding + CW'(acc) - CW'(resp);
  // In RUN nothing is owed a drop, so pcq_count equals outstanding; free slots
  // are counted after this cycle's pop so k=1 sustains one fetch per cycle.
  assign used      = (CW+1)'(pcq_count) + (CW+1)'(ibuf_count);
  assign credit_ok = used < ((CW+1)'(DEPTH) + (CW+1)'(pop));
  assign imem_req_addr = fetch_pc;

  always_comb begin
    state_d        = state_q;
    imem_req_valid = 1'b0;
    case (state_q)
      RUN:   imem_req_valid = run_en && credit_ok;
      FLUSH: if (resp && drop_cnt == CW'(1)) state_d = RUN;
      default: state_d = RUN;
    endcase
    if (pc_src_e) state_d = (drop_next != '0) ? FLUSH : RUN;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      run_en      <= 1'b0;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      state_q     <= state_d;
      run_en      <= 1'b1;
      outstanding <= drop_next;
      if (pc_src_e) begin
        fetch_pc <= pc_target_e;
        drop_cnt <= drop_next;
      end else begin
        if (acc) fetch_pc <= fetch_pc + ADDRESS_WIDTH'(4);
        if (state_q == FLUSH && resp) drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  // Addresses of live requests, oldest first; tags each response with its pc.
  fetch_fifo #(.WIDTH(ADDRESS_WIDTH), .DEPTH(DEPTH)) u_pcq (
    .clk(clk), .rst(rst), .flush(pc_src_e),
    .push(acc && !pc_src_e), .din(fetch_pc),
    .pop(resp && in_run), .dout(pcq_dout), .count(pcq_count)
  );

  assign ibuf_din = '{pc: pcq_dout, instr: imem_resp_data};

  fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_ibuf (
    .clk(clk), .rst(rst), .flush(pc_src_e),
    .push(resp && in_run), .din(ibuf_din),
    .pop(pop), .dout(ibuf_dout), .count(ibuf_count)
  );

  assign instr_valid_f = (ibuf_count != '0);
  assign pc_f          = instr_valid_f ? ibuf_dout.pc : '0;
  assign instr_f       = instr_valid_f ? ibuf_dout.instr : DATA_WIDTH'(NOP);
  assign pc_plus4_f    = pc_f + ADDRESS_WIDTH'(4);
endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch-stage controller for the pipelined RISC-V core. It owns the fetch PC and sequences requests to a multi-cycle instruction memory over a valid/ready request channel and an in-order response channel. Returned instructions go into a small in-order buffer that feeds decode. The block honours `stall_f` from the hazard unit and squashes in-flight fetches on an execute-stage redirect (`pc_src_e`/`pc_target_e`).

## Interface
- `ADDRESS_WIDTH`, 32, PC/address width
- `DATA_WIDTH`, 32, instruction width
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `DEPTH`, 2, instruction buffer entries and max outstanding requests (power of 2, ≥2)

- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: asynchronous, active-low reset
- `stall_f` in 1: hold head entry, no pop
- `pc_src_e` in 1: redirect strobe
- `pc_target_e` in ADDRESS_WIDTH: redirect address
- `imem_req_valid` out 1: fetch request
- `imem_req_ready` in 1: memory accepts request
- `imem_req_addr` out ADDRESS_WIDTH: request address
- `imem_resp_valid` in 1: in-order response strobe, always accepted
- `imem_resp_data` in DATA_WIDTH: response instruction
- `pc_f` out ADDRESS_WIDTH: PC of head entry
- `pc_plus4_f` out ADDRESS_WIDTH: `pc_f + 4`, combinational, wraps mod 2^ADDRESS_WIDTH
- `instr_f` out DATA_WIDTH: head instruction
- `instr_valid_f` out 1: head entry valid

## Operation
- Registers: `fetch_pc`, `outstanding` (0..DEPTH), `drop_cnt` (0..DEPTH), buffer of {pc, instr} with `count`, and FSM state.
- FSM:
  - RUN: `imem_req_valid = (outstanding + count < DEPTH)`; `imem_req_addr = fetch_pc`. On accept (valid && ready), `fetch_pc += 4` and `outstanding++`.
  - FLUSH: `imem_req_valid = 0`. Every response is discarded and decrements `drop_cnt`. When `drop_cnt` reaches 0, go to RUN.
- Redirect (`pc_src_e = 1`, in any state) takes priority over all other events:
  - Buffer is cleared.
  - `fetch_pc <= pc_target_e`.
  - `drop_cnt <= outstanding + acc − resp`, where `acc` = request accepted this cycle and `resp` = response this cycle. A response arriving in the redirect cycle is discarded.
  - Next state is FLUSH if `drop_cnt` is nonzero, otherwise RUN.
- Response in RUN: written into the buffer tail as {pc of oldest outstanding request, data}; `outstanding--`. The pc queue is a DEPTH-entry FIFO of issued addresses. The credit rule guarantees the buffer never overflows.
- Pop: when `instr_valid_f && !stall_f && !pc_src_e`. Simultaneous push and pop keeps `count` unchanged.
- Empty buffer: `instr_f` = NOP (32'h0000_0013), `pc_f` = 0, `instr_valid_f` = 0.
- `imem_req_addr` is held stable while `imem_req_valid` is high and not yet accepted. A redirect is the only event that may change it or drop valid.

## Timing
- Reset values: RUN, `fetch_pc` = RESET_PC, all counters 0, buffer empty, `imem_req_valid` = 0, `instr_valid_f` = 0, `instr_f` = NOP, `pc_f` = 0.
- First cycle after `rst` deasserts: `imem_req_valid` = 1 with address RESET_PC.
- Latency: accept at cycle N, response at N+k (k ≥ 1), `instr_valid_f` at N+k+1. There is no response-to-output bypass.
- Redirect at cycle R with nothing in flight: request to `pc_target_e` is issued at R+1.
- Reset mid-operation clears all state immediately. The memory shares `rst`, so no stale responses arrive after reset.
- Sustained throughput: one instruction per cycle when k = 1, memory is always ready, and there is no stall.

## Structure
- `fetch_pkg`: NOP constant, FSM state enum {RUN, FLUSH}.
- Sub-module `fetch_fifo`: parameterised synchronous FIFO with flush, reset and count output. Instantiated twice: pc queue for outstanding requests, and the {pc, instr} buffer.

## Test plan
- Reset then release, ready = 1, k = 1 → requests to 0x0, 0x4, 0x8 on consecutive cycles; `instr_valid_f` first at cycle 3 after release with `pc_f` = 0x0, `pc_plus4_f` = 0x4.
- `stall_f` held 6 cycles with DEPTH = 2 → buffer fills, `imem_req_valid` drops, `pc_f`/`instr_f` hold. After release, the sequence continues with no gaps or duplicates.
- `imem_req_ready` low for 3 cycles → `imem_req_valid` stays high with a constant address, and `fetch_pc` does not advance.
- Redirect to 0x100 with 2 outstanding requests → both responses dropped, no request during FLUSH. The next request is to 0x100, and the first valid `pc_f` is 0x100.
- Redirect in the same cycle as a request accept and a response → response discarded, `drop_cnt` = outstanding, and the accepted request's response is also dropped.
- Assert `rst` with a full buffer and requests in flight → all outputs take reset values asynchronously; after release, fetch restarts at RESET_PC.
